// File: rtl/fsm_sched_pkg.sv
// Shared types and helpers for the channelised second-one detector.
//   det_state_t : per-channel detector state (S0 = even number of ones seen,
//                 S1 = one pending)
//   next_rr     : round-robin pointer update after an arbitration cycle
package fsm_sched_pkg;

  typedef enum logic {S0 = 1'b0, S1 = 1'b1} det_state_t;

  // Pointer moves to the channel after the granted one, wrapping from
  // n_ch-1 back to 0; with no grant it holds.
  function automatic int unsigned next_rr(input int unsigned ptr,
                                          input int unsigned grant,
                                          input logic        grant_valid,
                                          input int unsigned n_ch);
    if (!grant_valid) return ptr;
    return (grant + 1 >= n_ch) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/pair_detect_core.sv
// Combinational "second-one" detector step: given the saved state of a
// channel and its next bit, produce the next state and the output bit.
// Ports:
//   st  : current channel state
//   d   : input bit
//   nst : next channel state
//   out : 1 when d completes a pair of ones
module pair_detect_core
  import fsm_sched_pkg::*;
(
  input  det_state_t st,
  input  logic       d,
  output det_state_t nst,
  output logic       out
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    nst = st;
    out = 1'b0;
    if (d) begin
      if (st == S1) begin
        nst = S0;
        out = 1'b1;
      end else begin
        nst = S1;
      end
    end
  end

endmodule

// File: rtl/fsm_ch_scheduler.sv
// Time-multiplexes one pair_detect_core across N_CH serial channels.
// A round-robin arbiter grants one channel bit per cycle; per-channel
// detector state and saturating detection counters live here.
// Ports:
//   clock, reset          : clock and asynchronous active-low reset
//   clear                 : synchronous clear of states, counters, pointer
//   req_valid/req_din     : per-channel bit offer
//   req_ready             : one-hot grant (transfer on valid & ready)
//   det_valid/det_ch/det_dout : registered result, one cycle after transfer
//   rd_ch/rd_cnt          : combinational counter readback
module fsm_ch_scheduler
  import fsm_sched_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH-1:0]   req_din,
  output logic [N_CH-1:0]   req_ready,
  output logic              det_valid,
  output logic [CH_W-1:0]   det_ch,
  output logic              det_dout,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int IW = CH_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  det_state_t        state_q [N_CH];
  logic [CNT_W-1:0]  cnt_q   [N_CH];
  logic [CH_W-1:0]   rr_ptr;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [IW-1:0]     scan_idx;
  logic              xfer;
  det_state_t        core_nst;
  logic              core_out;

  // Round-robin scan starting at rr_ptr; first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = {1'b0, rr_ptr} + IW'(k);
      if (scan_idx >= IW'(N_CH)) scan_idx = scan_idx - IW'(N_CH);
      if (!grant_found && req_valid[scan_idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CH_W-1:0];
      end
    end
  end

  // clear suppresses the grant so nothing transfers in a clearing cycle.
  assign xfer = grant_found && !clear;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  pair_detect_core u_core (
    .st  (state_q[grant_idx]),
    .d   (req_din[grant_idx]),
    .nst (core_nst),
    .out (core_out)
  );

  // NOTE: the state file and counters are small flop arrays that must come
  // out of reset at S0/0, so they are reset explicitly rather than left as RAM.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S0;
        cnt_q[i]   <= '0;
      end
      rr_ptr    <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_dout  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S0;
        cnt_q[i]   <= '0;
      end
      rr_ptr    <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_dout  <= 1'b0;
    end else begin
      det_valid <= xfer;
      det_dout  <= xfer && core_out;
      rr_ptr    <= CH_W'(next_rr(32'(rr_ptr), 32'(grant_idx), xfer, N_CH));
      if (xfer) begin
        state_q[grant_idx] <= core_nst;
        det_ch             <= grant_idx;
        if (core_out && cnt_q[grant_idx] != CNT_MAX)
          cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
      end
    end
  end

  // Out-of-range selects (possible when N_CH is not a power of two) read 0.
  always_comb begin
    rd_cnt = '0;
    if (32'(rd_ch) < N_CH) rd_cnt = cnt_q[rd_ch];
  end

endmodule

// File: tb/tb_fsm_ch_scheduler.sv
// Self-checking bench for fsm_ch_scheduler: directed scenarios plus random
// traffic against a behavioural model that counts ones per channel.
module tb_fsm_ch_scheduler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 2;
  localparam int CH_W  = $clog2(N_CH);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              clear;
  logic [N_CH-1:0]   req_valid;
  logic [N_CH-1:0]   req_din;
  logic [N_CH-1:0]   req_ready;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
  logic              det_dout;
  logic [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_cnt;

  fsm_ch_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .req_valid (req_valid),
    .req_din   (req_din),
    .req_ready (req_ready),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_dout  (det_dout),
    .rd_ch     (rd_ch),
    .rd_cnt    (rd_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: ones seen per channel, detections per channel,
  // round-robin pointer, and the expected registered result.
  int m_ones [N_CH];
  int m_cnt  [N_CH];
  int m_ptr;
  bit exp_valid;
  int exp_ch;
  bit exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_ones[i] = 0;
      m_cnt[i]  = 0;
    end
    m_ptr     = 0;
    exp_valid = 0;
    exp_ch    = 0;
    exp_dout  = 0;
  endtask

  task automatic check_counters();
    for (int c = 0; c < N_CH; c++) begin
      rd_ch = CH_W'(c);
      #1;
      check($sformatf("rd_cnt[%0d]", c), 32'(rd_cnt), 32'(m_cnt[c]));
    end
  endtask

  // One clock cycle with the currently applied inputs: check the grant,
  // advance the model at the edge, then check the registered result.
  task automatic cycle();
    int g;
    logic [N_CH-1:0] exp_rdy;
    bit pulse;
    g = -1;
    exp_rdy = '0;
    if (!clear) begin
      for (int k = 0; k < N_CH; k++) begin
        int idx;
        idx = (m_ptr + k) % N_CH;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clock);
    #1;
    if (clear) begin
      model_reset();
    end else if (g >= 0) begin
      pulse = 0;
      if (req_din[g]) begin
        m_ones[g]++;
        pulse = (m_ones[g] % 2 == 0);
      end
      if (pulse && m_cnt[g] < CMAX) m_cnt[g]++;
      m_ptr     = (g + 1) % N_CH;
      exp_valid = 1;
      exp_ch    = g;
      exp_dout  = pulse;
    end else begin
      exp_valid = 0;
    end
    check("det_valid", 32'(det_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("det_ch", 32'(det_ch), 32'(exp_ch));
      check("det_dout", 32'(det_dout), 32'(exp_dout));
    end
    check_counters();
  endtask

  task automatic drive(input logic [N_CH-1:0] v, input logic [N_CH-1:0] d, input logic clr);
    req_valid = v;
    req_din   = d;
    clear     = clr;
    cycle();
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    req_din   = '0;
    rd_ch     = '0;
    model_reset();

    // Reset state
    #2;
    check("rst det_valid", 32'(det_valid), 32'd0);
    check("rst det_ch", 32'(det_ch), 32'd0);
    check("rst det_dout", 32'(det_dout), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check_counters();
    #6 reset = 1'b1;
    @(posedge clock);
    #1;

    // Channel 0 back-to-back ones: 0,1,0,1 and count 2
    for (int i = 0; i < 4; i++) drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // All channels valid: strict rotation
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'($urandom), 1'b0);

    // Clear to a known state, then interleaved retention on ch1/ch2
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0010, 4'b0010, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    drive(4'b0010, 4'b0010, 1'b0);

    // Saturation on ch3: 10 pairs of ones
    for (int i = 0; i < 20; i++) drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    check("sat hold", 32'(rd_cnt), 32'(CMAX));

    // clear while ch0 is in S1 with requests pending
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b1111, 4'b1111, 1'b1);
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Random traffic with occasional clear
    for (int i = 0; i < 300; i++)
      drive(4'($urandom), 4'($urandom), ($urandom_range(0, 31) == 0));

    // Asynchronous reset between edges during traffic
    drive(4'b1111, 4'b1111, 1'b0);
    req_valid = 4'b1111;
    req_din   = 4'b1111;
    clear     = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async det_valid", 32'(det_valid), 32'd0);
    check("async det_dout", 32'(det_dout), 32'd0);
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(4'b1111, 4'b1111, 1'b0);

    // More random traffic after reset
    for (int i = 0; i < 100; i++)
      drive(4'($urandom), 4'($urandom), ($urandom_range(0, 63) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_ch_scheduler.md
Name: fsm_ch_scheduler

Overview:
Time-multiplexes one shared two-state "second-one" detector core across N_CH serial input channels. Per channel, the core drives the output to 1 on every second 1 bit. A round-robin arbiter grants one channel bit per cycle. Per-channel state is saved in a small state file, and per-channel detection counters are kept for coverage/readback. The block sits between the serial channel sources and the detection-event consumer.

Parameters:
N_CH, 4, number of serial channels (2..16)
CNT_W, 8, width of each per-channel detection counter
CH_W, $clog2(N_CH), channel index width (derived, not overridable)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear of all channel states, counters and rr pointer
req_valid  in  N_CH  channel i presents a bit
req_din  in  N_CH  bit value for channel i
req_ready  out  N_CH  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i]
det_valid  out  1  one-cycle pulse: core result available
det_ch  out  CH_W  channel of the result
det_dout  out  1  detector output for that bit
rd_ch  in  CH_W  counter readback select
rd_cnt  out  CNT_W  detection count of channel rd_ch (combinational read)

Behaviour:
- Reset is asynchronous, active-low, on reset; clock is clock. While reset is low:
  - all channel states = S0, counters = 0, rr pointer = 0
  - det_valid = 0, det_ch = 0, det_dout = 0
- Arbiter: combinational round-robin.
  - Scan begins at the rr pointer; the first channel with req_valid set gets req_ready (at most one bit set).
  - With no valid requests, req_ready = 0 and the pointer holds.
  - On a grant to channel g, the pointer becomes (g+1) mod N_CH. Wrap goes from N_CH-1 to 0.
- Core function, applied to the granted channel's saved state st and bit d:
  - S0 & d=1 -> S1, out 0
  - S0 & d=0 -> S0, out 0
  - S1 & d=1 -> S0, out 1
  - S1 & d=0 -> S1, out 0
- Latency: the state write-back for a channel transferred in cycle t is visible at edge t+1. det_valid, det_ch and det_dout are registered and valid in cycle t+1.
- Back-to-back grants to the same channel must use the updated state. The state file is written at the edge, so no bypass is needed.
- Throughput: one bit per cycle total. Ungranted channels keep req_valid and req_din stable until granted. A source that drops valid early loses its request, with no side effect.
- Counter: on det_dout = 1, the granted channel's counter increments and saturates at 2^CNT_W-1, with no wrap.
- clear = 1 has priority over everything:
  - req_ready = 0, so no transfer that cycle
  - next edge: all states S0, counters 0, pointer 0, det_valid 0
- A reset asserted mid-stream discards the in-flight result. det_valid drops asynchronously.
- rd_cnt is a combinational read of the counter array. A counter updated at edge t reads the new value after t.
- rd_ch >= N_CH returns 0.

Decomposition:
- Package fsm_sched_pkg contains:
  - typedef enum logic {S0=1'b0, S1=1'b1} det_state_t
  - function next_rr(ptr, grant) for the pointer update
- Sub-module pair_detect_core: purely combinational, (st, d) -> (nst, out). It is reusable by other channelised detectors.
- Arbiter, state file, counters and output registers stay in the top module.

Test Plan:
- Single channel 0, bits 1,1,1,1 back-to-back -> det_dout 0,1,0,1 on consecutive det_valid cycles, det_ch = 0, counter[0] = 2.
- All 4 channels valid every cycle, pointer at 0 -> grants 0,1,2,3,0,... each exactly once per 4 cycles. det_ch follows one cycle later.
- Interleaved state retention: ch1 bit 1, ch2 bits 1,1, then ch1 bit 1 -> ch1 output pulse only on its second 1, ch2 pulse on its second 1. States do not mix.
- Saturation with CNT_W = 2: 10 pairs of ones on ch3 -> rd_cnt(ch3) = 3 and holds.
- clear asserted while ch0 is in S1 with requests pending -> req_ready = 0 that cycle. Afterwards ch0 bit 1 gives det_dout 0 (state S0), and all counters read 0.
- reset driven low asynchronously between edges during traffic -> det_valid = 0 immediately. After release, the first grant goes to channel 0 and all states are S0.
